// File: rtl/edge_bbox_finder.sv
// Raster-scans a binary edge map through a 2-cycle-latency read port and reports
// the bounding box and count of set pixels once the whole frame has been read.
module edge_bbox_finder #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int MIN_COUNT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [18:0] read_addr,
    input  logic        read_data,
    output logic [9:0]  min_x,
    output logic [9:0]  max_x,
    output logic [8:0]  min_y,
    output logic [8:0]  max_y,
    output logic [18:0] edge_count,
    output logic        valid
);

    localparam int          STAGES  = 2;
    localparam logic [9:0]  X_LAST  = 10'(WIDTH - 1);
    localparam logic [8:0]  Y_LAST  = 9'(HEIGHT - 1);
    localparam logic [18:0] MIN_CNT = 19'(MIN_COUNT);
    localparam logic [18:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t      state;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        drain_cnt;

    logic [STAGES:1]       vld_pipe;
    logic [STAGES:1][9:0]  tag_x;
    logic [STAGES:1][8:0]  tag_y;

    logic [18:0] w_count;
    logic        w_hit;
    logic [9:0]  w_min_x, w_max_x;
    logic [8:0]  w_min_y, w_max_y;
    logic        hit;
    logic        w_valid;

    assign read_addr = (state == SCAN) ? {y, x} : 19'd0;
    assign hit       = vld_pipe[STAGES] & read_data;
    assign w_valid   = (w_count >= MIN_CNT);

    // Control FSM and result registers; a start in any state restarts the scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            drain_cnt  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            min_x      <= '0;
            max_x      <= '0;
            min_y      <= '0;
            max_y      <= '0;
            edge_count <= '0;
            valid      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state     <= SCAN;
                x         <= '0;
                y         <= '0;
                drain_cnt <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    SCAN: begin
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                y         <= '0;
                                drain_cnt <= 1'b0;
                                state     <= DRAIN;
                            end else begin
                                y <= y + 9'd1;
                            end
                        end else begin
                            x <= x + 10'd1;
                        end
                    end
                    DRAIN: begin
                        drain_cnt <= 1'b1;
                        if (drain_cnt) state <= DONE;
                    end
                    DONE: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        edge_count <= w_count;
                        valid      <= w_valid;
                        min_x      <= w_valid ? w_min_x : 10'd0;
                        max_x      <= w_valid ? w_max_x : 10'd0;
                        min_y      <= w_valid ? w_min_y : 9'd0;
                        max_y      <= w_valid ? w_max_y : 9'd0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Coordinate tags ride alongside the memory latency; a restart flushes in-flight reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            tag_x    <= '0;
            tag_y    <= '0;
        end else if (start) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], state == SCAN};
            tag_x    <= {tag_x[STAGES-1:1], x};
            tag_y    <= {tag_y[STAGES-1:1], y};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_count <= '0;
            w_hit   <= 1'b0;
            w_min_x <= '0;
            w_max_x <= '0;
            w_min_y <= '0;
            w_max_y <= '0;
        end else if (start) begin
            w_count <= '0;
            w_hit   <= 1'b0;
            w_min_x <= '0;
            w_max_x <= '0;
            w_min_y <= '0;
            w_max_y <= '0;
        end else if (hit) begin
            if (w_count != CNT_MAX) w_count <= w_count + 19'd1;
            w_hit <= 1'b1;
            if (!w_hit) begin
                w_min_x <= tag_x[STAGES];
                w_max_x <= tag_x[STAGES];
                w_min_y <= tag_y[STAGES];
                w_max_y <= tag_y[STAGES];
            end else begin
                if (tag_x[STAGES] < w_min_x) w_min_x <= tag_x[STAGES];
                if (tag_x[STAGES] > w_max_x) w_max_x <= tag_x[STAGES];
                if (tag_y[STAGES] < w_min_y) w_min_y <= tag_y[STAGES];
                if (tag_y[STAGES] > w_max_y) w_max_y <= tag_y[STAGES];
            end
        end
    end

endmodule

// File: tb/tb_edge_bbox_finder.sv
// Directed bench for edge_bbox_finder on an 8x4 map behind a 2-cycle-latency memory.
module tb_edge_bbox_finder;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [18:0] read_addr;
    logic        read_data;
    logic [9:0]  min_x, max_x;
    logic [8:0]  min_y, max_y;
    logic [18:0] edge_count;
    logic        valid;

    logic [31:0] edge_map;
    logic        d1;
    int          checks;
    int          failures;

    edge_bbox_finder #(.WIDTH(8), .HEIGHT(4), .MIN_COUNT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .read_addr(read_addr), .read_data(read_data),
        .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
        .edge_count(edge_count), .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic pix(input logic [18:0] a);
        int idx;
        if (a[18:10] >= 9'd4 || a[9:0] >= 10'd8) return 1'b0;
        idx = int'(a[18:10]) * 8 + int'(a[9:0]);
        return edge_map[idx];
    endfunction

    function automatic logic [31:0] px(input int x, input int y);
        return 32'd1 << (y * 8 + x);
    endfunction

    always @(posedge clk) begin
        d1        <= pix(read_addr);
        read_data <= d1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_scan(input int restart_at, output int lat, output int ndone,
                            output logic busy_d, output logic [18:0] addr9,
                            output logic [18:0] cnt_mid);
        int  n;
        bit  restarted;
        n = 0; restarted = 0; lat = 0; ndone = 0; busy_d = 1'b1;
        addr9 = '0; cnt_mid = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("addr_after_start", 32'(read_addr), 32'd0);
        for (int g = 0; g < 200 && n < 40; g++) begin
            @(negedge clk);
            if (start) begin
                start = 1'b0;
                n = 0;
            end else begin
                n++;
            end
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat    = n;
                    busy_d = busy;
                end
            end
            if (n == 9)  addr9   = read_addr;
            if (n == 20) cnt_mid = edge_count;
            if (restart_at != 0 && n == restart_at && !restarted) begin
                start     = 1'b1;
                restarted = 1;
            end
        end
    endtask

    task automatic scan_case(input string tag, input int restart_at, input int exp_mid,
                             input int cnt, input int vld, input int mnx, input int mxx,
                             input int mny, input int mxy);
        int          lat, ndone;
        logic        busy_d;
        logic [18:0] addr9, cnt_mid;
        run_scan(restart_at, lat, ndone, busy_d, addr9, cnt_mid);
        chk({tag, "_latency"}, 32'(lat), 32'd35);
        chk({tag, "_ndone"}, 32'(ndone), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy_d), 32'd0);
        chk({tag, "_addr_x1y1"}, 32'(addr9), 32'd1025);
        chk({tag, "_count_stable"}, 32'(cnt_mid), 32'(exp_mid));
        chk({tag, "_count"}, 32'(edge_count), 32'(cnt));
        chk({tag, "_valid"}, 32'(valid), 32'(vld));
        chk({tag, "_min_x"}, 32'(min_x), 32'(mnx));
        chk({tag, "_max_x"}, 32'(max_x), 32'(mxx));
        chk({tag, "_min_y"}, 32'(min_y), 32'(mny));
        chk({tag, "_max_y"}, 32'(max_y), 32'(mxy));
    endtask

    initial begin
        int extra;
        checks = 0; failures = 0;
        reset = 1'b0; start = 1'b0; edge_map = '0;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(read_addr), 32'd0);
        chk("rst_count", 32'(edge_count), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_box", 32'({min_x, max_x, min_y}), 32'd0);
        @(negedge clk); reset = 1'b1;

        edge_map = '0;
        scan_case("zero", 0, 0, 0, 0, 0, 0, 0, 0);

        edge_map = px(2, 1) | px(5, 3);
        scan_case("two", 0, 0, 2, 1, 2, 5, 1, 3);

        edge_map = px(7, 0);
        scan_case("single", 0, 2, 1, 0, 0, 0, 0, 0);

        edge_map = px(0, 0) | px(7, 0) | px(0, 3) | px(7, 3);
        scan_case("corners", 0, 1, 4, 1, 0, 7, 0, 3);

        // Reset ten cycles into a scan.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_addr", 32'(read_addr), 32'd0);
        chk("midrst_count", 32'(edge_count), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_max", 32'({max_x, max_y}), 32'd0);
        @(negedge clk); reset = 1'b1;
        extra = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("midrst_no_done", 32'(extra), 32'd0);

        edge_map = px(3, 2) | px(6, 2) | px(1, 1);
        scan_case("after_rst", 0, 0, 3, 1, 1, 6, 1, 2);

        // First pass sees (1,1) before the restart; the fresh scan must not.
        edge_map = px(1, 1) | px(4, 0) | px(4, 3);
        fork
            begin
                wait (start === 1'b1);
                @(negedge clk);
                wait (start === 1'b1);
                edge_map = px(4, 0) | px(4, 3);
            end
        join_none
        scan_case("restart", 20, 3, 2, 1, 4, 4, 0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
